fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter and fetch sequencer for the single-cycle accumulator CPU; sits upstream of
//  instruction_memory (drives its address) and downstream-forwards the fetched word to decode.
//  Absorbs the ROM's 1-cycle synchronous read: tracks which PC the ROM output belongs to,
//  squashes wrong-path words after redirects, supports stall, halt/resume and counts retirements.
// PARAMETERS
//  INSTRUCTION_WIDTH  10      width of ROM word / instruction
//  ADDR_BITS          6       PC / ROM address width
//  RESET_VECTOR       0       first address fetched after reset
//  COUNT_BITS         16      width of retired-instruction counter
// PORTS
//  clk          in   1                  clock; all state changes on posedge
//  rst_n        in   1                  reset, synchronous, active-low
//  rom_addr     out  ADDR_BITS          address to instruction_memory (combinational)
//  rom_data     in   INSTRUCTION_WIDTH  instruction_memory output (rom[addr] at previous edge)
//  stall        in   1                  decode cannot accept current instruction; hold it
//  redirect     in   1                  taken jump/branch this cycle
//  target       in   ADDR_BITS          redirect destination
//  halt         in   1                  current instruction is HLT
//  resume       in   1                  leave HALTED state
//  instr        out  INSTRUCTION_WIDTH  instruction to decode (= rom_data)
//  instr_pc     out  ADDR_BITS          address instr was fetched from
//  instr_valid  out  1                  instr is on the correct path and usable
//  halted       out  1                  FSM in HALTED
//  retired      out  COUNT_BITS         instructions accepted since reset, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge, any state, overrides all): state=FILL, pc=RESET_VECTOR,
//    instr_pc=0, instr_valid=0, retired=0. halted=0. rom_addr then = RESET_VECTOR.
//  - rom_addr = (state==RUN && stall) ? instr_pc : pc  -> ROM re-reads held word during stall.
//  - instr_valid = (state==RUN); halted = (state==HALTED); instr = rom_data always.
//  - FILL: next edge -> RUN, instr_pc<=pc, pc<=pc+1. Inputs ignored. (1-cycle bubble.)
//  - RUN, priority halt > redirect > stall > advance:
//     halt:     -> HALTED, pc<=instr_pc+1, retired++ (HLT itself retires); stall ignored.
//     redirect: -> FILL, pc<=target, retired++; word currently in ROM is squashed (1 bubble).
//     stall:    pc, instr_pc, state, retired hold.
//     advance:  instr_pc<=pc, pc<=pc+1, retired++.
//  - HALTED: redirect/stall/halt ignored; resume -> FILL (fetch restarts at held pc).
//  - pc+1 and instr_pc+1 wrap modulo 2**ADDR_BITS (max -> 0); no overflow flag.
//  - retired saturates at all-ones; never wraps.
//  - Throughput: 1 instr/cycle in RUN with no stall; redirect/resume penalty exactly 1 cycle.
// STRUCTURE
//  - cpu_defines.vh: FSM encodings FETCH_FILL=2'd0, FETCH_RUN=2'd1, FETCH_HALTED=2'd2; shared
//    INSTRUCTION_WIDTH/ADDR_BITS defaults, HLT opcode (used by decode, not here).
//  - One sub-module: sat_counter (COUNT_BITS, inc, sync active-low clear) for retired.
//  - FSM + pc/instr_pc registers in fetch_unit; connect to instruction_memory in cpu top.
// TESTING (bench instantiates fetch_unit + instruction_memory, ROM word = address pattern)
//  - Reset release, no stall: cycle1 valid=0 addr=0; then instr_pc=0,1,2.. valid=1 each cycle;
//    retired=3 after 3 valid cycles.
//  - Stall 3 cycles at instr_pc=5: instr/instr_pc stay 5, rom_addr=5, retired frozen;
//    release -> instr_pc=6 next cycle.
//  - redirect target=40 while instr_pc=7: next cycle valid=0 (word 8 squashed), then
//    instr_pc=40,41; redirect+stall together behaves as redirect.
//  - Wrap: run from 62 -> instr_pc 62,63,0,1 with valid=1 throughout.
//  - halt at instr_pc=10 with redirect=1: halted=1, valid=0, redirect ignored; 4 idle cycles
//    stable; resume -> 1 bubble then instr_pc=11.
//  - rst_n=0 mid-stall and in HALTED: next cycle state FILL, retired=0, rom_addr=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding and default geometry.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_FILL   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  localparam int INSTRUCTION_WIDTH_DEF = 10;
  localparam int ADDR_BITS_DEF         = 6;
  localparam int COUNT_BITS_DEF        = 16;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module fetch_unit_sat_counter #(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  inc,
  output logic [COUNT_BITS-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC and fetch sequencer: hides the ROM's one-cycle read latency, squashes wrong-path
// words after redirects, and supports stall, halt/resume and a retirement count.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter int ADDR_BITS         = ADDR_BITS_DEF,
  parameter int RESET_VECTOR      = 0,
  parameter int COUNT_BITS        = COUNT_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDR_BITS-1:0]         rom_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_data,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [ADDR_BITS-1:0]         target,
  input  logic                         halt,
  input  logic                         resume,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]         instr_pc,
  output logic                         instr_valid,
  output logic                         halted,
  output logic [COUNT_BITS-1:0]        retired
);

  localparam logic [ADDR_BITS-1:0] RESET_PC = ADDR_BITS'(RESET_VECTOR);

  fetch_state_t         state, state_nxt;
  logic [ADDR_BITS-1:0] pc, pc_nxt;
  logic [ADDR_BITS-1:0] instr_pc_nxt;
  logic                 retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH_FILL;
      pc       <= RESET_PC;
      instr_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_pc <= instr_pc_nxt;
    end
  end

  // pc always names the word the ROM will present next edge; instr_pc the word it shows now.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_pc_nxt = instr_pc;
    retire       = 1'b0;
    unique case (state)
      FETCH_FILL: begin
        state_nxt    = FETCH_RUN;
        instr_pc_nxt = pc;
        pc_nxt       = pc + 1'b1;
      end
      FETCH_RUN: begin
        if (halt) begin
          state_nxt = FETCH_HALTED;
          pc_nxt    = instr_pc + 1'b1;
          retire    = 1'b1;
        end else if (redirect) begin
          // The word already in flight belongs to the fall-through path; refill from target.
          state_nxt = FETCH_FILL;
          pc_nxt    = target;
          retire    = 1'b1;
        end else if (!stall) begin
          instr_pc_nxt = pc;
          pc_nxt       = pc + 1'b1;
          retire       = 1'b1;
        end
      end
      FETCH_HALTED: begin
        if (resume) begin
          state_nxt = FETCH_FILL;
        end
      end
      default: begin
        state_nxt = FETCH_FILL;
      end
    endcase
  end

  // During a stall the ROM re-reads the held word so rom_data stays put.
  assign rom_addr    = ((state == FETCH_RUN) && stall) ? instr_pc : pc;
  assign instr       = rom_data;
  assign instr_valid = (state == FETCH_RUN);
  assign halted      = (state == FETCH_HALTED);

  fetch_unit_sat_counter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_retired (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (retire),
    .count(retired)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural synchronous ROM whose word is {4'hA, addr}.
module tb_fetch_unit;

  localparam int IW = 10;
  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr, rom_addr_s;
  logic [IW-1:0] rom_data, rom_data_s;
  logic          stall, redirect, halt, resume;
  logic [AW-1:0] target;
  logic [IW-1:0] instr, instr_s;
  logic [AW-1:0] instr_pc, instr_pc_s;
  logic          instr_valid, instr_valid_s;
  logic          halted, halted_s;
  logic [CW-1:0] retired;
  logic [2:0]    retired_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data   <= {4'hA, rom_addr};
    rom_data_s <= {4'hA, rom_addr_s};
  end

  fetch_unit #(.INSTRUCTION_WIDTH(IW), .ADDR_BITS(AW), .RESET_VECTOR(0), .COUNT_BITS(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .redirect(redirect), .target(target), .halt(halt), .resume(resume),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted),
    .retired(retired)
  );

  // Narrow-counter copy used only to observe retirement saturation.
  fetch_unit #(.INSTRUCTION_WIDTH(IW), .ADDR_BITS(AW), .RESET_VECTOR(0), .COUNT_BITS(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .stall(stall), .redirect(redirect), .target(target), .halt(halt), .resume(resume),
    .instr(instr_s), .instr_pc(instr_pc_s), .instr_valid(instr_valid_s), .halted(halted_s),
    .retired(retired_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; resume = 1'b0; target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({instr_valid, halted, retired, rom_addr} !== {1'b0, 1'b0, 16'd0, 6'd0})
      $display("FAIL reset_state: valid=%0b halted=%0b retired=%0d addr=%0d required 0 0 0 0",
               instr_valid, halted, retired, rom_addr);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({instr_valid, instr_pc, instr, retired} !== {1'b1, 6'(i), {4'hA, 6'(i)}, 16'(i)})
        $display("FAIL run_%0d: valid=%0b pc=%0d instr=%h retired=%0d required 1 %0d %h %0d",
                 i, instr_valid, instr_pc, instr, retired, i, {4'hA, 6'(i)}, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    stall = 1'b1;
    #1;
    total_cnt++;
    if ({instr_pc, rom_addr, retired} !== {6'd5, 6'd5, 16'd5})
      $display("FAIL stall_enter: pc=%0d addr=%0d retired=%0d required 5 5 5",
               instr_pc, rom_addr, retired);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({instr_valid, instr_pc, instr, rom_addr, retired} !==
          {1'b1, 6'd5, {4'hA, 6'd5}, 6'd5, 16'd5})
        $display("FAIL stall_hold_%0d: pc=%0d instr=%h addr=%0d retired=%0d required 5 %h 5 5",
                 i, instr_pc, instr, rom_addr, retired, {4'hA, 6'd5});
      else pass_cnt++;
    end
    stall = 1'b0;
    step();
    total_cnt++;
    if ({instr_valid, instr_pc, instr, retired} !== {1'b1, 6'd6, {4'hA, 6'd6}, 16'd6})
      $display("FAIL stall_release: pc=%0d instr=%h retired=%0d required 6 %h 6",
               instr_pc, instr, retired, {4'hA, 6'd6});
    else pass_cnt++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    redirect = 1'b1; target = 6'd40;
    step();
    redirect = 1'b0;
    #1;
    total_cnt++;
    if ({instr_valid, rom_addr, retired} !== {1'b0, 6'd40, 16'd8})
      $display("FAIL redirect_bubble: valid=%0b addr=%0d retired=%0d required 0 40 8",
               instr_valid, rom_addr, retired);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 6'(40 + i), {4'hA, 6'(40 + i)}})
        $display("FAIL redirect_target_%0d: valid=%0b pc=%0d instr=%h required 1 %0d",
                 i, instr_valid, instr_pc, instr, 40 + i);
      else pass_cnt++;
    end
    redirect = 1'b1; stall = 1'b1; target = 6'd20;
    step();
    redirect = 1'b0; stall = 1'b0;
    #1;
    total_cnt++;
    if ({instr_valid, retired} !== {1'b0, 16'd10})
      $display("FAIL redirect_stall_bubble: valid=%0b retired=%0d required 0 10",
               instr_valid, retired);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({instr_valid, instr_pc} !== {1'b1, 6'd20})
      $display("FAIL redirect_stall_target: valid=%0b pc=%0d required 1 20", instr_valid, instr_pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_pc [4];
    exp_pc[0] = 6'd62; exp_pc[1] = 6'd63; exp_pc[2] = 6'd0; exp_pc[3] = 6'd1;
    redirect = 1'b1; target = 6'd62;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[i], {4'hA, exp_pc[i]}})
        $display("FAIL wrap_%0d: valid=%0b pc=%0d instr=%h required 1 %0d",
                 i, instr_valid, instr_pc, instr, exp_pc[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (retired_s !== 3'd7)
      $display("FAIL retired_saturate: got %0d required 7", retired_s);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 11; i++) step();
    halt = 1'b1; redirect = 1'b1; target = 6'd33;
    step();
    halt = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({halted, instr_valid, rom_addr, retired} !== {1'b1, 1'b0, 6'd11, 16'd11})
        $display("FAIL halt_idle_%0d: halted=%0b valid=%0b addr=%0d retired=%0d required 1 0 11 11",
                 i, halted, instr_valid, rom_addr, retired);
      else pass_cnt++;
      if (i < 4) step();
    end
    redirect = 1'b0; stall = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    total_cnt++;
    if ({halted, instr_valid, rom_addr} !== {1'b0, 1'b0, 6'd11})
      $display("FAIL resume_bubble: halted=%0b valid=%0b addr=%0d required 0 0 11",
               halted, instr_valid, rom_addr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({instr_valid, instr_pc, instr, retired} !== {1'b1, 6'd11, {4'hA, 6'd11}, 16'd11})
      $display("FAIL resume_fetch: valid=%0b pc=%0d instr=%h retired=%0d required 1 11 %h 11",
               instr_valid, instr_pc, instr, retired, {4'hA, 6'd11});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1;
    step(); step();
    rst_n = 1'b0;
    step();
    total_cnt++;
    if ({instr_valid, halted, retired, rom_addr} !== {1'b0, 1'b0, 16'd0, 6'd0})
      $display("FAIL reset_in_stall: valid=%0b halted=%0b retired=%0d addr=%0d required 0 0 0 0",
               instr_valid, halted, retired, rom_addr);
    else pass_cnt++;
    rst_n = 1'b1; stall = 1'b0;
    for (int i = 0; i < 4; i++) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    #1;
    total_cnt++;
    if ({halted, retired} !== {1'b1, 16'd4})
      $display("FAIL halt_before_reset: halted=%0b retired=%0d required 1 4", halted, retired);
    else pass_cnt++;
    rst_n = 1'b0;
    step();
    total_cnt++;
    if ({instr_valid, halted, retired, rom_addr} !== {1'b0, 1'b0, 16'd0, 6'd0})
      $display("FAIL reset_in_halt: valid=%0b halted=%0b retired=%0d addr=%0d required 0 0 0 0",
               instr_valid, halted, retired, rom_addr);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
